// File: rtl/iob_fifo_wr_arbiter.sv
// iob_fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among N_REQ packet producers
module iob_fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 16,
  localparam int REQ_W = $clog2(N_REQ),
  localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    fifo_w_en_o,
  output logic [DATA_W-1:0]       fifo_w_data_o,
  input  logic                    fifo_w_full_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [REQ_W-1:0]        grant_idx_o,
  output logic                    busy_o
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [REQ_W-1:0] ptr, win, nxt;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] d [N_REQ];
  logic xfer, rel;
  for (genvar k = 0; k < N_REQ; k++) begin : g_d
    assign d[k] = req_data_i[k*DATA_W +: DATA_W];
  end
  assign xfer = state == XFER;
  assign fifo_w_data_o = d[grant_idx_o];
  assign req_ready_o = (xfer && rst_n_i && !fifo_w_full_i) ? grant_o : '0;
  assign fifo_w_en_o = xfer & rst_n_i & ~fifo_w_full_i & req_valid_i[grant_idx_o];
  assign rel = fifo_w_en_o & (req_last_i[grant_idx_o] | cnt == CNT_W'(MAX_BURST - 1));
  assign nxt = grant_idx_o == REQ_W'(N_REQ - 1) ? '0 : grant_idx_o + 1'b1;
  // scan from the far end so the requester closest to ptr wins
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid_i[(int'(ptr) + i) % N_REQ]) win = REQ_W'((int'(ptr) + i) % N_REQ);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      grant_o <= '0;
      grant_idx_o <= '0;
      busy_o <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else if (!xfer) begin
      if (|req_valid_i) begin
        state <= XFER;
        grant_o <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
        grant_idx_o <= win;
        busy_o <= 1'b1;
        cnt <= '0;
      end
    end else if (rel) begin
      state <= IDLE;
      grant_o <= '0;
      grant_idx_o <= '0;
      busy_o <= 1'b0;
      ptr <= nxt;
      cnt <= '0;
    end else if (fifo_w_en_o) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_iob_fifo_wr_arbiter.sv
// tb_iob_fifo_wr_arbiter: directed checks of grant order, burst cap, full stall, reset and 3-way wrap
module tb_iob_fifo_wr_arbiter;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n = 0;
  logic [3:0] valid = '0, last = '0, ready, grant;
  logic [127:0] data = '0;
  logic full = 0, w_en, busy;
  logic [31:0] w_data;
  logic [1:0] gidx;
  logic [2:0] v3 = '0, l3 = '0, r3, g3;
  logic [23:0] d3 = '0;
  logic [7:0] wd3;
  logic [1:0] gi3;
  logic we3, b3;
  int tests = 0, fails = 0;

  iob_fifo_wr_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready), .fifo_w_en_o(w_en), .fifo_w_data_o(w_data), .fifo_w_full_i(full),
    .grant_o(grant), .grant_idx_o(gidx), .busy_o(busy));

  iob_fifo_wr_arbiter #(.N_REQ(3), .DATA_W(8), .MAX_BURST(4)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v3), .req_data_i(d3), .req_last_i(l3),
    .req_ready_o(r3), .fifo_w_en_o(we3), .fifo_w_data_o(wd3), .fifo_w_full_i(1'b0),
    .grant_o(g3), .grant_idx_o(gi3), .busy_o(b3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    tick;
    rst_n = 1;
    settle;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", gidx, 0);
    chk("rst_wen", w_en, 0);
    // single requester, 3-beat packet
    valid = 4'b0010;
    data[32 +: 32] = 32'hD0;
    settle;
    chk("s1_arb_wen", w_en, 0);
    tick;
    chk("s1_grant", grant, 4'b0010);
    chk("s1_idx", gidx, 1);
    chk("s1_busy", busy, 1);
    chk("s1_ready", ready, 4'b0010);
    chk("s1_wen0", w_en, 1);
    chk("s1_d0", w_data, 32'hD0);
    tick;
    data[32 +: 32] = 32'hD1;
    settle;
    chk("s1_wen1", w_en, 1);
    chk("s1_d1", w_data, 32'hD1);
    tick;
    data[32 +: 32] = 32'hD2;
    last = 4'b0010;
    settle;
    chk("s1_wen2", w_en, 1);
    chk("s1_d2", w_data, 32'hD2);
    tick;
    valid = '0;
    last = '0;
    settle;
    chk("s1_rel_grant", grant, 0);
    chk("s1_rel_busy", busy, 0);
    // ptr is now 2: with 0,1,3 valid the winner must be 3
    valid = 4'b1011;
    last = 4'b1111;
    for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'hA0 + k;
    tick;
    chk("ptr2_grant", grant, 4'b1000);
    tick;
    valid = 4'b1111;
    settle;
    chk("ptr2_rel", grant, 0);
    // all four valid, 1-beat packets, ptr=0
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 5; n++) begin
        chk($sformatf("rr%0d_bubble", n), w_en, 0);
        tick;
        chk($sformatf("rr%0d_grant", n), grant, 4'b0001 << order[n]);
        chk($sformatf("rr%0d_wen", n), w_en, 1);
        chk($sformatf("rr%0d_data", n), w_data, 32'hA0 + order[n]);
        tick;
      end
    end
    // burst cap: req 2 sends 20 beats, req 3 waiting; ptr=1
    valid = 4'b1100;
    last = 4'b1000;
    data[64 +: 32] = 0;
    tick;
    chk("bc_grant2", grant, 4'b0100);
    for (int b = 0; b < 16; b++) begin
      data[64 +: 32] = b;
      settle;
      chk($sformatf("bc_b%0d", b), {w_en, w_data}, {1'b1, 32'(b)});
      tick;
    end
    chk("bc_cut_grant", grant, 0);
    chk("bc_cut_wen", w_en, 0);
    tick;
    chk("bc_grant3", grant, 4'b1000);
    chk("bc_data3", w_data, 32'hA3);
    tick;
    valid = 4'b0100;
    settle;
    chk("bc_bubble2", grant, 0);
    tick;
    chk("bc_regrant2", grant, 4'b0100);
    for (int b = 16; b < 20; b++) begin
      data[64 +: 32] = b;
      last = (b == 19) ? 4'b0100 : 4'b0000;
      settle;
      chk($sformatf("bc_b%0d", b), {w_en, w_data}, {1'b1, 32'(b)});
      tick;
    end
    valid = '0;
    last = '0;
    settle;
    chk("bc_done", grant, 0);
    // FIFO full during beats 2..4 of a 6-beat req 0 packet; ptr=3
    valid = 4'b0001;
    data[0 +: 32] = 32'h100;
    tick;
    chk("ff_grant", grant, 4'b0001);
    chk("ff_b0", {w_en, w_data}, {1'b1, 32'h100});
    tick;
    data[0 +: 32] = 32'h101;
    full = 1;
    for (int c = 0; c < 3; c++) begin
      settle;
      chk($sformatf("ff_stall%0d", c), {ready, w_en, grant}, {4'b0000, 1'b0, 4'b0001});
      tick;
    end
    full = 0;
    for (int b = 1; b < 6; b++) begin
      data[0 +: 32] = 32'h100 + b;
      last = (b == 5) ? 4'b0001 : 4'b0000;
      settle;
      chk($sformatf("ff_b%0d", b), {ready, w_en, w_data}, {4'b0001, 1'b1, 32'h100 + 32'(b)});
      tick;
    end
    valid = '0;
    last = '0;
    settle;
    chk("ff_done", grant, 0);
    // reset during beat 5 of a req 1 packet; ptr=1
    valid = 4'b0010;
    tick;
    chk("rs_grant", grant, 4'b0010);
    for (int b = 0; b < 4; b++) begin
      data[32 +: 32] = 32'h200 + b;
      settle;
      chk($sformatf("rs_b%0d", b), w_en, 1);
      tick;
    end
    rst_n = 0;
    settle;
    chk("rs_wen_low", {ready, w_en}, 0);
    tick;
    rst_n = 1;
    valid = 4'b0011;
    settle;
    chk("rs_after", {grant, busy}, 0);
    tick;
    chk("rs_from0", grant, 4'b0001);
    last = 4'b0011;
    tick;
    valid = '0;
    last = '0;
    tick;
    // N_REQ=3 wrap: grant 2 releases, ptr must wrap to 0
    v3 = 3'b100;
    l3 = 3'b111;
    d3 = 24'h22_11_00;
    tick;
    chk("w3_grant2", {g3, gi3}, {3'b100, 2'd2});
    chk("w3_data2", {we3, wd3}, {1'b1, 8'h22});
    tick;
    v3 = 3'b011;
    settle;
    chk("w3_rel", g3, 0);
    tick;
    chk("w3_next0", {g3, gi3}, {3'b001, 2'd0});
    tick;
    v3 = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iob_fifo_wr_arbiter.md
Name: iob_fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of a synchronous FIFO between N_REQ producers.
- Each producer streams packets over a valid/ready handshake.
- A granted producer keeps the write port until it sends its last beat, or until it hits a burst cap, whichever comes first.
- The block sits directly in front of the FIFO write port (w_en/w_data/w_full). Releasing the grant after the burst cap bounds worst-case latency for the other requesters.

Parameters:
- N_REQ, 4, number of requesters; must be ≥2.
- DATA_W, 32, FIFO write data width.
- MAX_BURST, 16, maximum beats per grant; must be ≥1.
- REQ_W, $clog2(N_REQ), requester index width (derived).
- CNT_W, $clog2(MAX_BURST+1), beat counter width (derived).

Ports:
- clk_i, input, 1, clock.
- rst_n_i, input, 1, reset: one clock; reset is synchronous and active-low.
- req_valid_i, input, N_REQ, per-requester beat valid.
- req_data_i, input, N_REQ*DATA_W, per-requester beat data; requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i, input, N_REQ, marks the final beat of a packet.
- req_ready_o, output, N_REQ, per-requester beat accepted.
- fifo_w_en_o, output, 1, FIFO write enable.
- fifo_w_data_o, output, DATA_W, FIFO write data.
- fifo_w_full_i, input, 1, FIFO full flag.
- grant_o, output, N_REQ, one-hot current owner; all zero when idle.
- grant_idx_o, output, REQ_W, binary index of current owner.
- busy_o, output, 1, high while in XFER.

Behaviour:
- Reset: sampled on the rising edge while rst_n_i=0. It forces:
  - state=IDLE;
  - grant_o=0, grant_idx_o=0, busy_o=0;
  - priority pointer ptr=0;
  - beat count cnt=0.
  While rst_n_i=0, req_ready_o and fifo_w_en_o are forced to 0 combinationally. This applies mid-packet too: the packet is abandoned, no partial-packet cleanup.
- State IDLE:
  - If no req_valid_i bit is set, stay in IDLE.
  - Otherwise pick the winner: the first set bit scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - Register grant_o=onehot(winner), grant_idx_o=winner, cnt=0, and go to XFER.
  - Arbitration latency is 1 cycle from req_valid_i to grant_o. No beat is accepted in the arbitration cycle.
- State XFER, with g = grant_idx_o:
  - req_ready_o[g] = ~fifo_w_full_i. All other ready bits are 0.
  - fifo_w_en_o = req_valid_i[g] & ~fifo_w_full_i. Combinational, zero added latency.
  - fifo_w_data_o = req_data_i[g], always muxed by grant_idx_o. In IDLE it equals req_data_i[0] (don't-care).
  - Accepted beat (acc): fifo_w_en_o=1. On acc, cnt increments.
  - Release: acc & (req_last_i[g] | cnt==MAX_BURST-1). On release:
    - go to IDLE;
    - ptr = (g+1) mod N_REQ, wrapping N_REQ-1 → 0;
    - grant_o=0.
  - One idle bubble cycle follows every release; back-to-back grants are not pipelined.
  - req_valid_i[g]=0 in XFER: hold the grant and wait; there is no timeout.
  - fifo_w_full_i=1: no acceptance, grant held, cnt frozen.
  - A burst cut at MAX_BURST does not end the packet. The requester re-arbitrates and continues later; its req_last_i is honoured on a subsequent grant.
- Requester rules:
  - Data, last and valid must be held stable while valid=1 and ready=0.
  - Valid bits of non-granted requesters are ignored, never dropped.
- Fairness: a requester with valid continuously high waits at most (N_REQ-1)*(MAX_BURST+1) write-port-available cycles before its grant.
- Widths:
  - ptr and grant_idx_o are REQ_W bits. When N_REQ is not a power of two, wrap explicitly at N_REQ-1.
  - cnt is CNT_W bits and never exceeds MAX_BURST-1 in state.

Test Plan:
- Reset then single requester: req 1 sends a 3-beat packet (last on beat 3), FIFO never full → grant_o=4'b0010 one cycle after valid; fifo_w_en_o high 3 consecutive cycles with data D0,D1,D2; grant_o=0 the next cycle; ptr=2.
- All four requesters valid with 1-beat packets, starting from ptr=0 → grant order 0,1,2,3,0; each grant lasts 1 cycle followed by 1 bubble; 4 writes in 8 cycles.
- Burst cap: MAX_BURST=16, requester 2 sends a 20-beat packet while requester 3 is also valid → 16 beats written, then requester 3 is served, then requester 2's remaining 4 beats with last.
- FIFO full mid-packet: requester 0, fifo_w_full_i=1 during beats 2–4 → req_ready_o[0]=0 and fifo_w_en_o=0 for those cycles; no beat duplicated or lost; cnt resumes.
- rst_n_i=0 for 1 cycle during beat 5 of a requester 1 packet → fifo_w_en_o=0 in that cycle; after the edge: grant_o=0, ptr=0, busy_o=0; a new arbitration starts from requester 0.
- N_REQ=3 wrap: grant requester 2 releases → ptr=0, not 3; next winner is 0 when requesters 0 and 1 are both valid.
